scan_imem_loader: RTL
=====================

Name: scan_imem_loader

Overview:
- Serial-to-parallel loader between the external scan port and the instruction memory write port of rv_uart_top.
- Samples scan_in while scan_en is high and decodes a command frame: op bit, word count, start address, data words.
- Issues one IMEM write per completed word; with readback compiled in, it can instead read IMEM words and shift them out on scan_out.
- Holds the CPU while a frame is active.

Parameters:
- ADDR_W, 12: IMEM byte-address width driven on imem_addr.
- CNT_W, 32: width of the word-count and address fields in the frame. All fields are sent LSB first.

Ports:
- clk  in  1  system clock. The scan port is sampled on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- scan_en  in  1  frame enable. Low aborts and returns to IDLE.
- scan_in  in  1  serial data in, LSB first.
- scan_out  out  1  serial readback data, LSB first.
- imem_we  out  1  one-cycle IMEM write strobe.
- imem_re  out  1  one-cycle IMEM read strobe.
- imem_addr  out  ADDR_W  IMEM byte address. Bits [1:0] are always 0.
- imem_wdata  out  32  write data, valid while imem_we is high.
- imem_rdata  in  32  read data, valid the cycle after imem_re.
- cpu_hold  out  1  high while scan_en is high or state is not IDLE.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and all counters and shift registers are 0.
- Frame format: op (1 bit; 1 = write, 0 = read), count (CNT_W bits), address (CNT_W bits), then data. All fields are LSB first, one bit per clk while scan_en is high.
- States: IDLE, LEN, ADDR, WDATA, RREQ, RLATCH, RSHIFT, DONE.
- IDLE: if scan_en is high, sample scan_in as op and go to LEN.
- LEN: shift CNT_W bits into cnt, then go to ADDR.
- ADDR: shift CNT_W bits.
  - Load the addr register with bits [ADDR_W-1:2] of the shifted value; low two bits are forced to 0.
  - Next state: if cnt == 0, go to DONE. Otherwise go to WDATA if op == 1, or RREQ if op == 0.
- WDATA: shift 32 bits into wbuf.
  - The cycle after the 32nd bit is sampled: imem_we = 1, imem_wdata = wbuf, imem_addr = addr, for exactly one cycle.
  - That same cycle, the first bit of the next word is sampled, so words stream back to back with no gaps.
  - After each write: addr += 4, wrapping modulo 2^ADDR_W; cnt -= 1.
  - When cnt reaches 0, go to DONE.
  - cnt == all-ones means unbounded: cnt never decrements, and the frame ends only when scan_en drops.
- RREQ: imem_re = 1 for one cycle. Go to RLATCH.
- RLATCH: rbuf = imem_rdata. Go to RSHIFT.
- RSHIFT: scan_out = rbuf[0], shifting right once per cycle for 32 cycles.
  - Then addr += 4 and cnt -= 1.
  - Go to RREQ, or to DONE when cnt reaches 0. The all-ones unbounded rule also applies here.
  - scan_out is 0 in every state except RSHIFT.
  - scan_in is ignored during read states.
- DONE: ignore scan_in and wait for scan_en == 0, then go to IDLE. A new frame requires scan_en to go low first.
- scan_en low in any non-IDLE state: go to IDLE on the next edge.
  - A partial word is discarded and no strobe is issued.
  - A write strobe already registered for that cycle still completes.
- Simultaneous write strobe and scan_en fall: the strobe completes and the state goes to IDLE.
- cnt == 1: exactly one write or read, then DONE.
- Address wrap: from (2^ADDR_W - 4), the next address is 0.
- Latency: imem_we asserts 1 cycle after the last data bit. The first scan_out bit appears 2 cycles after the last address bit.

Optional Feature:
- Macro: SCAN_READBACK_EN.
- Defined: read frames (op = 0) operate as described above.
- Undefined: RREQ, RLATCH, RSHIFT and rbuf are not built. op = 0 goes from ADDR straight to DONE; imem_re and scan_out are tied to 0.

Test Plan:
- Write stream:
  - Stimulus: op = 1, count = 0xFFFFFFFF, addr = 0, then 8 words 0x00012117, 0x04010113, 0x00022517, 0x03c50513, 0x2f5000ef, 0x00000097, 0x00c08093, 0x008000ef, then scan_en = 0.
  - Response: 8 imem_we pulses spaced exactly 32 cycles apart, at addresses 0x000 through 0x01C step 4, with matching data; no 9th pulse; busy = 0 one cycle after scan_en falls.
- Bounded write:
  - Stimulus: op = 1, count = 2, addr = 0x103, words 0xDEADBEEF, 0x12345678, then a third word is scanned.
  - Response: writes at 0x100 and 0x104 only; state is DONE during the third word; cpu_hold stays 1 until scan_en = 0.
- Abort:
  - Stimulus: scan_en drops after 20 data bits.
  - Response: no imem_we; state returns to IDLE the next cycle.
- Wrap:
  - Stimulus: count = 2, addr = 0xFFC with ADDR_W = 12.
  - Response: writes at 0xFFC then 0x000.
- Readback (SCAN_READBACK_EN):
  - Stimulus: preload IMEM[0x8] = 0xA5A5_0F0F; send op = 0, count = 1, addr = 8.
  - Response: imem_re with imem_addr = 8; 2 cycles after the address, scan_out shows 0xA5A50F0F over 32 cycles, LSB first.
- Reset mid-frame:
  - Stimulus: assert Rst during WDATA.
  - Response: all outputs are 0 immediately (asynchronously); no write occurs.

Source files
------------

// File: rtl/scan_imem_loader_if.sv
// -----------------------------------------------------------------------------
// scan_imem_loader_if
//   Bundles the external scan port and the IMEM write/read port that sit on
//   either side of scan_imem_loader.
//
//   master : the loader (samples scan_en/scan_in/imem_rdata and drives the rest)
//   slave  : the environment (scan source + instruction memory + CPU hold sink)
//
//   Signals
//     scan_en    frame enable; low aborts any frame in progress
//     scan_in    serial data, LSB first, sampled on rising clk while scan_en=1
//     scan_out   serial readback data, LSB first
//     imem_we    one-cycle write strobe; imem_addr/imem_wdata valid with it
//     imem_re    one-cycle read strobe; imem_rdata valid the following cycle
//     imem_addr  IMEM byte address (bits [1:0] always 0)
//     imem_wdata IMEM write data
//     imem_rdata IMEM read data
//     cpu_hold   holds the CPU while a frame is active
//     busy       loader FSM is not idle
// -----------------------------------------------------------------------------
interface scan_imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              scan_en;
    logic              scan_in;
    logic              scan_out;
    logic              imem_we;
    logic              imem_re;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       imem_rdata;
    logic              cpu_hold;
    logic              busy;

    modport master (
        input  scan_en, scan_in, imem_rdata,
        output scan_out, imem_we, imem_re, imem_addr, imem_wdata, cpu_hold, busy
    );

    modport slave (
        output scan_en, scan_in, imem_rdata,
        input  scan_out, imem_we, imem_re, imem_addr, imem_wdata, cpu_hold, busy
    );
endinterface

// File: rtl/scan_imem_loader.sv
// -----------------------------------------------------------------------------
// scan_imem_loader
//   Serial-to-parallel loader between the scan port and the IMEM port.
//   A frame is: op (1 = write, 0 = read), count (CNT_W bits), address
//   (CNT_W bits), then 32-bit data words, every field LSB first, one bit per
//   clk while scan_en is high. count == all-ones streams until scan_en drops.
//
//   Optional readback: define SCAN_READBACK_EN to build the read path
//   (RREQ/RLATCH/RSHIFT). Without it a read frame goes straight to DONE and
//   imem_re/scan_out are tied low.
//
//   Ports
//     clk        system clock, scan port sampled on rising edge
//     rst        asynchronous active-high reset
//     bus        scan_imem_loader_if.master (scan port + IMEM port)
//     dbg_state  current FSM state encoding
//
//   Strobe semantics: there is no back-pressure. imem_we and imem_re are
//   single-cycle strobes; the memory must accept a write in the strobe cycle
//   and present read data on the cycle after imem_re. scan_en acts as the
//   only "valid" for scan_in; a cycle with scan_en low is never sampled.
// -----------------------------------------------------------------------------
module scan_imem_loader #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    scan_imem_loader_if.master bus,
    output logic [2:0]         dbg_state
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
`ifdef SCAN_READBACK_EN
    localparam logic [2:0] S_RREQ   = 3'd4;
    localparam logic [2:0] S_RLATCH = 3'd5;
    localparam logic [2:0] S_RSHIFT = 3'd6;
`endif
    localparam logic [2:0] S_DONE   = 3'd7;

    // One bit counter serves both the CNT_W-bit header fields and 32-bit words.
    localparam int BC_MAX = (CNT_W > 32) ? CNT_W : 32;
    localparam int BC_W   = $clog2(BC_MAX);
    localparam int AI_W   = $clog2(ADDR_W);
    localparam logic [BC_W-1:0] FIELD_LAST = BC_W'(CNT_W - 1);
    localparam logic [BC_W-1:0] WORD_LAST  = BC_W'(31);

    logic [2:0]        state;
    logic              op;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [BC_W-1:0]   bcnt;
    logic [31:0]       wbuf;
    logic              we_q;
    logic              re_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
`ifdef SCAN_READBACK_EN
    logic [31:0]       rbuf;
`endif

    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] addr_step;
    logic [CNT_W-1:0]  cnt_dec;
    logic [31:0]       word_in;
    logic              cnt_last;

    // Address bits arrive LSB first; only bits [ADDR_W-1:2] are kept, so the
    // incoming bit is dropped straight into its final position and the low
    // two bits stay at the zero they were cleared to at frame start.
    always_comb begin
        addr_in = addr;
        if (int'(bcnt) >= 2 && int'(bcnt) < ADDR_W) begin
            addr_in[bcnt[AI_W-1:0]] = bus.scan_in;
        end
    end

    assign addr_step = addr + ADDR_W'(4);          // wraps modulo 2^ADDR_W
    assign cnt_dec   = (&cnt) ? cnt : cnt - CNT_W'(1); // all-ones never counts down
    assign cnt_last  = (cnt == CNT_W'(1));
    assign word_in   = {bus.scan_in, wbuf[31:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op      <= 1'b0;
            cnt     <= '0;
            addr    <= '0;
            bcnt    <= '0;
            wbuf    <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef SCAN_READBACK_EN
            rbuf    <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            if (state != S_IDLE && !bus.scan_en) begin
                // Abort: partial word dropped. A strobe registered on the
                // previous edge is already on the bus and completes normally.
                state <= S_IDLE;
                bcnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.scan_en) begin
                            op    <= bus.scan_in;
                            cnt   <= '0;
                            addr  <= '0;
                            bcnt  <= '0;
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        cnt <= {bus.scan_in, cnt[CNT_W-1:1]};
                        if (bcnt == FIELD_LAST) begin
                            bcnt  <= '0;
                            state <= S_ADDR;
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                    S_ADDR: begin
                        addr <= addr_in;
                        if (bcnt == FIELD_LAST) begin
                            bcnt <= '0;
                            if (cnt == '0) begin
                                state <= S_DONE;
                            end else if (op) begin
                                state <= S_WDATA;
                            end else begin
`ifdef SCAN_READBACK_EN
                                re_q   <= 1'b1;
                                addr_q <= addr_in;
                                state  <= S_RREQ;
`else
                                state  <= S_DONE;
`endif
                            end
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                    S_WDATA: begin
                        wbuf <= word_in;
                        if (bcnt == WORD_LAST) begin
                            // Strobe goes out next cycle while the first bit
                            // of the following word is already being sampled.
                            bcnt    <= '0;
                            we_q    <= 1'b1;
                            wdata_q <= word_in;
                            addr_q  <= addr;
                            addr    <= addr_step;
                            cnt     <= cnt_dec;
                            if (cnt_last) begin
                                state <= S_DONE;
                            end
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
`ifdef SCAN_READBACK_EN
                    S_RREQ: begin
                        state <= S_RLATCH;
                    end
                    S_RLATCH: begin
                        rbuf  <= bus.imem_rdata;
                        bcnt  <= '0;
                        state <= S_RSHIFT;
                    end
                    S_RSHIFT: begin
                        rbuf <= {1'b0, rbuf[31:1]};
                        if (bcnt == WORD_LAST) begin
                            bcnt <= '0;
                            addr <= addr_step;
                            cnt  <= cnt_dec;
                            if (cnt_last) begin
                                state <= S_DONE;
                            end else begin
                                re_q   <= 1'b1;
                                addr_q <= addr_step;
                                state  <= S_RREQ;
                            end
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
`endif
                    S_DONE: begin
                        // Hold here until scan_en drops (handled above).
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.busy       = (state != S_IDLE);
    // scan_en is raw input; gating with rst keeps every output low in reset.
    assign bus.cpu_hold   = ~rst & (bus.scan_en | (state != S_IDLE));
    assign dbg_state      = state;

`ifdef SCAN_READBACK_EN
    assign bus.imem_re  = re_q;
    assign bus.scan_out = (state == S_RSHIFT) ? rbuf[0] : 1'b0;
`else
    logic unused_rd;
    assign unused_rd    = ^{bus.imem_rdata, re_q};
    assign bus.imem_re  = 1'b0;
    assign bus.scan_out = 1'b0;
`endif
endmodule
